au_core: RTL and testbench

Arithmetic-unit responder for the AU command interface driven by the AU controller. It captures operands, opcode and swap controls on `au_start`. It executes one integer or modular operation over a selectable modulus, either the field prime or the group order, and returns the result with a one-cycle `au_vld` pulse. Modular multiplication is a bit-serial interleaved (MSB-first double-and-add) loop.

---
 rtl/au_pkg.sv | 32 +++
 rtl/au_if.sv | 29 ++
 rtl/au_modmul_step.sv | 24 ++
 rtl/au_core.sv | 163 ++++++++++++++++
 tb/tb_au_core.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/au_pkg.sv
// Shared definitions for the AU responder: opcode map, opcode field positions,
// FSM encoding and the default secp256k1 moduli.
package au_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_PASS = 4'b0010;
    localparam logic [3:0] OP_MADD = 4'b1000;
    localparam logic [3:0] OP_MMUL = 4'b1001;
    localparam logic [3:0] OP_MSUB = 4'b1010;

    localparam int OP_MOD_BIT  = 3;
    localparam int OP_MSEL_BIT = 2;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] SECP256K1_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } au_state_e;

    // The modulus-select bit is ignored here, so MMUL over P and N both match.
    function automatic logic is_mmul(input logic [3:0] op);
        return op[OP_MOD_BIT] && (op[1:0] == OP_MMUL[1:0]);
    endfunction

endpackage

// File: rtl/au_if.sv
// AU command interface between the controller (master) and the arithmetic
// unit (slave).
interface au_if #(
    parameter int WIDTH = 256
);
    // au_start is a one-cycle strobe with no ready: the slave takes it only in
    // IDLE or DONE and silently drops it otherwise. au_vld pulses for one cycle
    // with au_rslt/au_rswap, which then hold until the next result.
    logic [WIDTH-1:0] au_dat1;
    logic [WIDTH-1:0] au_dat2;
    logic             au_carry;
    logic             au_start;
    logic [3:0]       au_opcode;
    logic             au_swapop;
    logic             au_swapvl;
    logic [WIDTH-1:0] au_rslt;
    logic [WIDTH-1:0] au_rswap;
    logic             au_vld;

    modport master (
        output au_dat1, au_dat2, au_carry, au_start, au_opcode, au_swapop, au_swapvl,
        input  au_rslt, au_rswap, au_vld
    );

    modport slave (
        input  au_dat1, au_dat2, au_carry, au_start, au_opcode, au_swapop, au_swapvl,
        output au_rslt, au_rswap, au_vld
    );
endinterface

// File: rtl/au_modmul_step.sv
// One MSB-first interleaved modular multiply iteration:
// acc_next = (2*acc mod m [+ b] ) mod m, each step reduced once.
module au_modmul_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] b,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next
);
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] dbl_red;
    logic [WIDTH:0] sum;

    always_comb begin
        m_ext    = {1'b0, m};
        dbl      = {acc, 1'b0};
        dbl_red  = (dbl >= m_ext) ? dbl - m_ext : dbl;
        sum      = bit_in ? dbl_red + {1'b0, b} : dbl_red;
        acc_next = WIDTH'((sum >= m_ext) ? sum - m_ext : sum);
    end
endmodule

// File: rtl/au_core.sv
// AU responder: latches a command on au_start, runs one integer or modular
// operation (bit-serial for MMUL) and returns the result with a one-cycle au_vld.
module au_core
    import au_pkg::*;
#(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] MOD_P = WIDTH'(SECP256K1_P),
    parameter logic [WIDTH-1:0] MOD_N = WIDTH'(SECP256K1_N)
) (
    input  logic      clk,
    input  logic      rst,
    au_if.slave       bus,
    output au_state_e dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    au_state_e        state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [3:0]       op_q,     op_d;
    logic             carry_q,  carry_d;
    logic             swapvl_q, swapvl_d;
    logic             fin_q,    fin_d;
    logic [WIDTH-1:0] rslt_q,   rslt_d;
    logic [WIDTH-1:0] rswap_q,  rswap_d;
    logic             vld_q,    vld_d;

    logic [WIDTH-1:0] mod_m;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [WIDTH:0]   mod_ext;

    assign mod_m = op_q[OP_MSEL_BIT] ? MOD_N : MOD_P;

    au_modmul_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .b        (b_q),
        .bit_in   (a_q[cnt_q]),
        .m        (mod_m),
        .acc_next (step_acc)
    );

    // Single-cycle ops from the latched operands; MMUL and reserved codes yield 0.
    always_comb begin
        simple_res = '0;
        sum_ext    = {1'b0, a_q} + {1'b0, b_q};
        dif_ext    = {1'b0, a_q} - {1'b0, b_q};
        mod_ext    = {1'b0, mod_m};
        if (!op_q[OP_MOD_BIT]) begin
            if (!op_q[OP_MSEL_BIT]) begin
                case (op_q[1:0])
                    OP_ADD[1:0]:  simple_res = a_q + b_q + WIDTH'(carry_q);
                    OP_SUB[1:0]:  simple_res = a_q - b_q - WIDTH'(carry_q);
                    OP_PASS[1:0]: simple_res = a_q;
                    default:      simple_res = '0;
                endcase
            end
        end else begin
            case (op_q[1:0])
                OP_MADD[1:0]: simple_res = (sum_ext >= mod_ext) ? WIDTH'(sum_ext - mod_ext)
                                                                : sum_ext[WIDTH-1:0];
                OP_MSUB[1:0]: simple_res = dif_ext[WIDTH] ? WIDTH'(dif_ext + mod_ext)
                                                          : dif_ext[WIDTH-1:0];
                default:      simple_res = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        op_d     = op_q;
        carry_d  = carry_q;
        swapvl_d = swapvl_q;
        fin_d    = fin_q;
        rslt_d   = rslt_q;
        rswap_d  = rswap_q;
        vld_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.au_start) begin
                    a_d      = bus.au_swapop ? bus.au_dat2 : bus.au_dat1;
                    b_d      = bus.au_swapop ? bus.au_dat1 : bus.au_dat2;
                    op_d     = bus.au_opcode;
                    carry_d  = bus.au_carry;
                    swapvl_d = bus.au_swapvl;
                    cnt_d    = CW'(WIDTH - 1);
                    acc_d    = '0;
                    fin_d    = 1'b0;
                    state_d  = is_mmul(bus.au_opcode) ? MUL : EXEC;
                end
            end
            EXEC: begin
                rslt_d  = simple_res;
                rswap_d = swapvl_q ? a_q : b_q;
                vld_d   = 1'b1;
                state_d = DONE;
            end
            MUL: begin
                // fin_q marks that the bit-0 iteration is already in acc_q.
                if (fin_q) begin
                    rslt_d  = acc_q;
                    rswap_d = swapvl_q ? a_q : b_q;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d = step_acc;
                    if (cnt_q == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            swapvl_q <= 1'b0;
            fin_q    <= 1'b0;
            rslt_q   <= '0;
            rswap_q  <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            swapvl_q <= swapvl_d;
            fin_q    <= fin_d;
            rslt_q   <= rslt_d;
            rswap_q  <= rswap_d;
            vld_q    <= vld_d;
        end
    end

    assign bus.au_rslt  = rslt_q;
    assign bus.au_rswap = rswap_q;
    assign bus.au_vld   = vld_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_au_core.sv
// Scoreboard bench for au_core at WIDTH=8 with P=251, N=239.
module tb_au_core;
  import au_pkg::*;

  localparam int W  = 8;
  localparam int MP = 251;
  localparam int MN = 239;
  localparam logic [W-1:0] P8 = 8'd251;
  localparam logic [W-1:0] N8 = 8'd239;

  logic      clk;
  logic      rst;
  au_state_e dbg_state;
  int        cyc;
  int        checks;
  int        errors;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [2*W-1:0] mon_exp;
  int             mon_cyc;

  au_if #(.WIDTH(W)) bus ();

  au_core #(.WIDTH(W), .MOD_P(P8), .MOD_N(N8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // reference model: plain integer arithmetic on the post-swap operands
  function automatic logic [2*W-1:0] model(input logic [3:0] op, input logic [W-1:0] d1,
                                           input logic [W-1:0] d2, input logic c,
                                           input logic sop, input logic svl);
    int a, b, m, r, s;
    logic [W-1:0] rv, sv;
    a = sop ? int'(d2) : int'(d1);
    b = sop ? int'(d1) : int'(d2);
    m = op[2] ? MN : MP;
    case (op)
      4'b0000:          r = (a + b + int'(c)) % 256;
      4'b0001:          r = (a - b - int'(c) + 512) % 256;
      4'b0010:          r = a;
      4'b1000, 4'b1100: r = (a + b) % m;
      4'b1001, 4'b1101: r = (a * b) % m;
      4'b1010, 4'b1110: r = (a - b + m) % m;
      default:          r = 0;
    endcase
    s  = svl ? a : b;
    rv = r[W-1:0];
    sv = s[W-1:0];
    return {rv, sv};
  endfunction

  // monitor: every au_vld must match the oldest expectation, including its cycle
  always @(negedge clk) begin
    if (bus.au_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld: got au_vld=1 rslt=%0d expected no response (cycle %0d)",
                 bus.au_rslt, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        chk("rslt",    int'(bus.au_rslt),  int'(mon_exp[2*W-1:W]));
        chk("rswap",   int'(bus.au_rswap), int'(mon_exp[W-1:0]));
        chk("vld_cyc", cyc, mon_cyc);
      end
    end
  end

  // driver: call at a negedge; start is high for exactly one cycle
  task automatic drive_cmd(input logic [3:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                           input logic c, input logic sop, input logic svl, input bit expect_resp);
    bus.au_opcode = op;
    bus.au_dat1   = d1;
    bus.au_dat2   = d2;
    bus.au_carry  = c;
    bus.au_swapop = sop;
    bus.au_swapvl = svl;
    bus.au_start  = 1'b1;
    if (expect_resp) begin
      exp_q.push_back(model(op, d1, d2, c, sop, svl));
      exp_cyc_q.push_back(cyc + ((op[3] && op[1:0] == 2'b01) ? W + 2 : 2));
    end
    @(negedge clk);
    bus.au_start  = 1'b0;
    bus.au_opcode = 4'($urandom);
    bus.au_dat1   = W'($urandom);
    bus.au_dat2   = W'($urandom);
    bus.au_carry  = 1'($urandom);
    bus.au_swapop = 1'($urandom);
    bus.au_swapvl = 1'($urandom);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                       input logic c, input logic sop, input logic svl);
    @(negedge clk);
    drive_cmd(op, d1, d2, c, sop, svl, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic wait_vld();
    for (int i = 0; i < 100; i++) begin
      if (bus.au_vld) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL vld_timeout: got no au_vld expected one within 100 cycles");
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rslt"},  int'(bus.au_rslt),  0);
    chk({tag, "_rswap"}, int'(bus.au_rswap), 0);
    chk({tag, "_vld"},   int'(bus.au_vld),   0);
    chk({tag, "_state"}, int'(dbg_state),    int'(IDLE));
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] d1, d2;
    int           m;
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.au_start  = 1'b0;
    bus.au_opcode = '0;
    bus.au_dat1   = '0;
    bus.au_dat2   = '0;
    bus.au_carry  = 1'b0;
    bus.au_swapop = 1'b0;
    bus.au_swapvl = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // directed cases
    issue(4'b0000, 8'd200, 8'd100, 1'b1, 1'b0, 1'b0);  wait_drain();
    issue(4'b0001, 8'd5,   8'd10,  1'b0, 1'b0, 1'b0);  wait_drain();
    issue(4'b1000, 8'd250, 8'd3,   1'b0, 1'b0, 1'b0);  wait_drain();
    issue(4'b1110, 8'd3,   8'd10,  1'b0, 1'b0, 1'b0);  wait_drain();
    issue(4'b1010, 8'd10,  8'd3,   1'b0, 1'b1, 1'b1);  wait_drain();
    issue(4'b0010, 8'd77,  8'd12,  1'b1, 1'b0, 1'b1);  wait_drain();
    issue(4'b1001, 8'd250, 8'd250, 1'b0, 1'b0, 1'b0);  wait_drain();
    issue(4'b1101, 8'd17,  8'd19,  1'b0, 1'b0, 1'b0);  wait_drain();
    issue(4'b1001, 8'd0,   8'd123, 1'b0, 1'b0, 1'b1);  wait_drain();

    // start pulsed during MMUL must be dropped
    issue(4'b1001, 8'd7, 8'd9, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drive_cmd(4'b0000, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    repeat (5) @(negedge clk);

    // back-to-back: new start in the DONE cycle
    issue(4'b0000, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);
    wait_vld();
    drive_cmd(4'b0001, 8'd9, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // reset in the middle of MMUL: no response, outputs cleared
    issue(4'b1001, 8'd3, 8'd5, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("midrst");
    repeat (15) @(negedge clk);

    // reserved opcodes
    issue(4'b0011, 8'd44, 8'd55, 1'b1, 1'b0, 1'b0);  wait_drain();
    issue(4'b0101, 8'd44, 8'd55, 1'b0, 1'b1, 1'b1);  wait_drain();
    issue(4'b1111, 8'd44, 8'd55, 1'b0, 1'b0, 1'b1);  wait_drain();

    // randomized commands, modular operands kept below the modulus
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      m  = op[2] ? MN : MP;
      if (op[3]) begin
        d1 = W'($urandom_range(0, m - 1));
        d2 = W'($urandom_range(0, m - 1));
      end else begin
        d1 = W'($urandom_range(0, 255));
        d2 = W'($urandom_range(0, 255));
      end
      issue(op, d1, d2, 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        wait_drain();
      end else begin
        wait_vld();
        drive_cmd(4'b0000, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'b1);
        wait_drain();
      end
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
